vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port synchronous VRAM between the pixel-fetch pipeline (reads) and CPU writes.
- CPU writes are buffered in a small FIFO and drained only while the video timing reports `writable` (vertical blanking).
- Pixel fetch always has priority.
- Also produces a one-cycle vblank interrupt pulse for the CPU side.

Parameters:
- ADDR_W, 12, VRAM address width.
- DATA_W, 8, VRAM data width.
- FIFO_DEPTH, 4, CPU write FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  pixel clock (12.5875 MHz).
- rst  in  1  synchronous, active-high reset.
- writable  in  1  high during vertical blanking (from video timing).
- fetch_req  in  1  pixel-fetch read request, one cycle per read.
- fetch_addr  in  ADDR_W  pixel-fetch read address.
- fetch_valid  out  1  read data valid.
- fetch_data  out  DATA_W  read data.
- cpu_wr_en  in  1  CPU write strobe.
- cpu_addr  in  ADDR_W  CPU write address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_wr_ready  out  1  FIFO can accept a write this cycle.
- overflow  out  1  sticky: a write was attempted while full.
- pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- vblank_irq  out  1  single-cycle pulse at start of blanking.
- vram_addr  out  ADDR_W  VRAM address.
- vram_we  out  1  VRAM write enable.
- vram_wdata  out  DATA_W  VRAM write data.
- vram_rdata  in  DATA_W  VRAM read data, valid one cycle after address.

Behaviour:
- Reset values:
  - FIFO empty; `pending`=0, `cpu_wr_ready`=1.
  - `fetch_valid`=0, `fetch_data`=0, `overflow`=0, `vblank_irq`=0.
  - `vram_we`=0, `vram_addr`=0, `vram_wdata`=0.
  - The `writable` history register resets to 1, so reset release never fires an IRQ.
  - Reset mid-drain discards all FIFO contents.
- Per-cycle grant (combinational, evaluated each cycle, priority order):
  1. `fetch_req` → READ: `vram_addr`=`fetch_addr`, `vram_we`=0.
  2. Else `writable` && `pending`≠0 → WRITE: `vram_addr`/`vram_wdata` from the FIFO head, `vram_we`=1, pop.
  3. Else IDLE: `vram_we`=0, `vram_addr`=0, `vram_wdata`=0.
- The VRAM port signals are combinational from the grant. No multi-cycle state, so a write never straddles a `writable` edge. A drain in progress stops on the first cycle `writable`=0; remaining entries wait for the next blanking.
- Read latency:
  - `fetch_valid` is registered: high exactly one cycle after a READ grant.
  - `fetch_data` is registered from `vram_rdata` in that cycle and holds its value otherwise.
  - Back-to-back requests give back-to-back valids.
- FIFO:
  - `cpu_wr_ready` = (`pending` < FIFO_DEPTH), based on the registered count before any same-cycle pop.
  - Push when `cpu_wr_en` && `cpu_wr_ready`.
  - Simultaneous push and pop: count unchanged, order preserved.
  - `cpu_wr_en` while full: the write is dropped, `overflow` is set and stays set until `rst`.
  - Pointers wrap modulo FIFO_DEPTH.
  - Writes to the same address drain in FIFO order.
- IRQ: `vblank_irq` = `writable` && !`writable_q`, registered (asserted the cycle after `writable` rises, for one cycle).
- No combinational path from `cpu_*` to `vram_*`: a write pushed in cycle N can pop no earlier than cycle N+1.

Test Plan:
- Reset, then hold `writable`=0 and push 3 writes (0x010←0xAA, 0x011←0xBB, 0x012←0xCC) → `pending`=3, `vram_we` never high. Raise `writable` → three consecutive `vram_we` cycles in order, `pending` decrements 3→2→1→0.
- `writable`=1, FIFO holding 2 entries, `fetch_req` pulsed with `fetch_addr`=0x200 and `vram_rdata`=0x5A → that cycle is READ with no write. Next cycle `fetch_valid`=1, `fetch_data`=0x5A, and the drain resumes.
- Push 5 writes while `writable`=0 (depth 4) → `cpu_wr_ready`=0 after the 4th, the 5th is dropped, `overflow`=1. `overflow` stays 1 after the FIFO drains and clears only on `rst`.
- Full FIFO, `writable`=1, `cpu_wr_en` held each cycle → first cycle rejected (`ready`=0, `overflow` set). Afterwards one push and one pop per cycle, `pending` steady at 3 or 4, data written in push order.
- `writable` drops after 2 of 4 writes drain → `vram_we` is 0 the same cycle, `pending` holds 2. Next `writable` rise → `vblank_irq` one-cycle pulse, remaining 2 writes drain.
- Assert `rst` with `pending`=3 mid-drain → next cycle `pending`=0, `vram_we`=0, `fetch_valid`=0. After release with `writable`=1 held high, no `vblank_irq` pulse.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: pixel-fetch reads always win; CPU writes are queued in a
// small FIFO and drained only while the video timing reports writable.
module vram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          writable,
    input  logic                          fetch_req,
    input  logic [ADDR_W-1:0]             fetch_addr,
    output logic                          fetch_valid,
    output logic [DATA_W-1:0]             fetch_data,
    input  logic                          cpu_wr_en,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    output logic                          cpu_wr_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          vblank_irq,
    output logic [ADDR_W-1:0]             vram_addr,
    output logic                          vram_we,
    output logic [DATA_W-1:0]             vram_wdata,
    input  logic [DATA_W-1:0]             vram_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {GNT_IDLE, GNT_READ, GNT_WRITE} grant_t;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_fetch_valid;
    logic [DATA_W-1:0] r_fetch_data;
    logic              r_writable_q;
    logic              r_irq;

    grant_t w_grant;
    logic   w_ready;
    logic   w_push;
    logic   w_pop;

    // Ready looks only at the registered count, so a same-cycle pop never
    // frees a slot for a push and no cpu_* input reaches the VRAM port.
    assign w_ready = (r_count < CW'(FIFO_DEPTH));
    assign w_push  = cpu_wr_en && w_ready;
    assign w_pop   = (w_grant == GNT_WRITE);

    always_comb begin
        w_grant = GNT_IDLE;
        if (fetch_req)
            w_grant = GNT_READ;
        else if (writable && (r_count != '0))
            w_grant = GNT_WRITE;
    end

    always_comb begin
        vram_addr  = '0;
        vram_we    = 1'b0;
        vram_wdata = '0;
        case (w_grant)
            GNT_READ:  vram_addr = fetch_addr;
            GNT_WRITE: begin
                vram_addr  = r_fifo_addr[r_rptr];
                vram_wdata = r_fifo_data[r_rptr];
                vram_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= cpu_addr;
            r_fifo_data[r_wptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
            r_writable_q  <= 1'b1;
            r_irq         <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
            if (cpu_wr_en && !w_ready)
                r_overflow <= 1'b1;
            r_fetch_valid <= (w_grant == GNT_READ);
            if (w_grant == GNT_READ)
                r_fetch_data <= vram_rdata;
            // History resets high so leaving reset during blanking is not an edge.
            r_writable_q <= writable;
            r_irq        <= writable && !r_writable_q;
        end
    end

    assign cpu_wr_ready = w_ready;
    assign overflow     = r_overflow;
    assign pending      = r_count;
    assign fetch_valid  = r_fetch_valid;
    assign fetch_data   = r_fetch_data;
    assign vblank_irq   = r_irq;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scenario bench for vram_arbiter: queued CPU writes and pixel reads are
// scoreboarded and checked by a negedge monitor; tasks check control outputs.
module tb_vram_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              writable;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              cpu_wr_en;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_wr_ready;
    logic              overflow;
    logic [2:0]        pending;
    logic              vblank_irq;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_wdata;
    logic [DATA_W-1:0] vram_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]        rd_q[$];

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .writable(writable),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wr_ready(cpu_wr_ready), .overflow(overflow), .pending(pending),
        .vblank_irq(vblank_irq), .vram_addr(vram_addr), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;

    // Monitor: expected grant from the bench's own queue occupancy.
    logic                     mon_we;
    logic [ADDR_W+DATA_W-1:0] mon_w;
    logic [DATA_W-1:0]        mon_r;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rd_q.delete();
        end else begin
            mon_we = !fetch_req && writable && (exp_q.size() != 0);
            vectors++;
            if (vram_we !== mon_we) begin
                miscompares++;
                $display("FAIL grant_we: got %b expected %b", vram_we, mon_we);
            end
            if (mon_we && vram_we === 1'b1) begin
                mon_w = exp_q.pop_front();
                vectors++;
                if ({vram_addr, vram_wdata} !== mon_w) begin
                    miscompares++;
                    $display("FAIL write_data: got %h/%h expected %h/%h",
                             vram_addr, vram_wdata, mon_w[ADDR_W+DATA_W-1:DATA_W], mon_w[DATA_W-1:0]);
                end
            end
            if (fetch_req) begin
                vectors++;
                if (vram_addr !== fetch_addr || vram_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL read_grant: got addr %h we %b expected addr %h we 0",
                             vram_addr, vram_we, fetch_addr);
                end
            end
            vectors++;
            if (rd_q.size() != 0) begin
                mon_r = rd_q.pop_front();
                if (fetch_valid !== 1'b1 || fetch_data !== mon_r) begin
                    miscompares++;
                    $display("FAIL fetch_return: got valid %b data %h expected valid 1 data %h",
                             fetch_valid, fetch_data, mon_r);
                end
            end else if (fetch_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fetch_idle: got valid %b expected 0", fetch_valid);
            end
            if (fetch_req) rd_q.push_back(vram_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU write attempt; acceptance decided from the bench's queue.
    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit acc;
        cpu_wr_en = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        acc = (exp_q.size() < DEPTH);
        tick();
        cpu_wr_en = 1'b0;
        if (acc) exp_q.push_back({a, d});
    endtask

    task automatic test_reset(input logic wr);
        rst = 1'b1; writable = wr; fetch_req = 1'b0; cpu_wr_en = 1'b0;
        fetch_addr = '0; cpu_addr = '0; cpu_wdata = '0; vram_rdata = '0;
        tick(); tick();
        vectors++;
        if (pending !== 3'd0 || cpu_wr_ready !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fifo: got pending %0d ready %b ovf %b expected 0 1 0",
                     pending, cpu_wr_ready, overflow);
        end
        vectors++;
        if (fetch_valid !== 1'b0 || fetch_data !== 8'h00 || vblank_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: got fv %b fd %h irq %b expected 0 00 0",
                     fetch_valid, fetch_data, vblank_irq);
        end
        vectors++;
        if (vram_we !== 1'b0 || vram_addr !== 12'h000 || vram_wdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_vram: got we %b addr %h wdata %h expected 0 000 00",
                     vram_we, vram_addr, vram_wdata);
        end
        rst = 1'b0;
        exp_q.delete();
        rd_q.delete();
    endtask

    task automatic test_drain_order();
        logic [2:0] exp_p;
        test_reset(1'b0);
        push(12'h010, 8'hAA);
        push(12'h011, 8'hBB);
        push(12'h012, 8'hCC);
        tick();
        vectors++;
        if (pending !== 3'd3) begin
            miscompares++;
            $display("FAIL hold_pending: got %0d expected 3", pending);
        end
        writable = 1'b1;
        exp_p = 3'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (pending !== exp_p) begin
                miscompares++;
                $display("FAIL drain_pending: got %0d expected %0d", pending, exp_p);
            end
            tick();
            if (exp_p != 0) exp_p = exp_p - 3'd1;
        end
    endtask

    task automatic test_fetch_priority();
        test_reset(1'b0);
        push(12'h020, 8'h11);
        push(12'h021, 8'h22);
        writable   = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 12'h200;
        vram_rdata = 8'h5A;
        #1;
        vectors++;
        if (vram_we !== 1'b0 || vram_addr !== 12'h200 || pending !== 3'd2) begin
            miscompares++;
            $display("FAIL fetch_prio: got we %b addr %h pending %0d expected 0 200 2",
                     vram_we, vram_addr, pending);
        end
        tick();
        fetch_req = 1'b0;
        #1;
        vectors++;
        if (fetch_valid !== 1'b1 || fetch_data !== 8'h5A || vram_we !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_resume: got fv %b fd %h we %b expected 1 5a 1",
                     fetch_valid, fetch_data, vram_we);
        end
        vram_rdata = 8'h00;
        tick(); tick(); tick();
        vectors++;
        if (pending !== 3'd0 || fetch_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL fetch_done: got pending %0d fd %h expected 0 5a", pending, fetch_data);
        end
        // Back-to-back reads give back-to-back valids (monitor checks the data).
        for (int i = 0; i < 3; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 12'h300 + 12'(i);
            vram_rdata = 8'h70 + 8'(i);
            tick();
        end
        fetch_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_overflow();
        test_reset(1'b0);
        for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), 8'h30 + 8'(i));
        vectors++;
        if (cpu_wr_ready !== 1'b0 || pending !== 3'd4 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full: got ready %b pending %0d ovf %b expected 0 4 0",
                     cpu_wr_ready, pending, overflow);
        end
        push(12'h1FF, 8'hEE);
        vectors++;
        if (overflow !== 1'b1 || pending !== 3'd4) begin
            miscompares++;
            $display("FAIL overflow_set: got ovf %b pending %0d expected 1 4", overflow, pending);
        end
        writable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (overflow !== 1'b1 || pending !== 3'd0) begin
            miscompares++;
            $display("FAIL overflow_sticky: got ovf %b pending %0d expected 1 0", overflow, pending);
        end
    endtask

    task automatic test_back_to_back();
        test_reset(1'b0);
        for (int i = 0; i < 4; i++) push(12'h400 + 12'(i), 8'h50 + 8'(i));
        writable = 1'b1;
        #1;
        vectors++;
        if (cpu_wr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first_ready: got %b expected 0", cpu_wr_ready);
        end
        push(12'h4F0, 8'h90);
        vectors++;
        if (overflow !== 1'b1 || pending !== 3'd3) begin
            miscompares++;
            $display("FAIL b2b_reject: got ovf %b pending %0d expected 1 3", overflow, pending);
        end
        for (int i = 0; i < 6; i++) begin
            push(12'h500 + 12'(i), 8'hA0 + 8'(i));
            vectors++;
            if (pending !== 3'd3) begin
                miscompares++;
                $display("FAIL b2b_steady: got %0d expected 3", pending);
            end
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_partial_drain();
        test_reset(1'b0);
        for (int i = 0; i < 4; i++) push(12'h600 + 12'(i), 8'hC0 + 8'(i));
        writable = 1'b1;
        tick(); tick();
        writable = 1'b0;
        #1;
        vectors++;
        if (vram_we !== 1'b0 || pending !== 3'd2) begin
            miscompares++;
            $display("FAIL drain_stop: got we %b pending %0d expected 0 2", vram_we, pending);
        end
        tick(); tick(); tick();
        vectors++;
        if (pending !== 3'd2 || vblank_irq !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_wait: got pending %0d irq %b expected 2 0", pending, vblank_irq);
        end
        writable = 1'b1;
        tick();
        vectors++;
        if (vblank_irq !== 1'b1 || pending !== 3'd1) begin
            miscompares++;
            $display("FAIL irq_pulse: got irq %b pending %0d expected 1 1", vblank_irq, pending);
        end
        tick();
        vectors++;
        if (vblank_irq !== 1'b0 || pending !== 3'd0) begin
            miscompares++;
            $display("FAIL irq_single: got irq %b pending %0d expected 0 0", vblank_irq, pending);
        end
    endtask

    task automatic test_reset_mid_drain();
        test_reset(1'b0);
        for (int i = 0; i < 4; i++) push(12'h700 + 12'(i), 8'hD0 + 8'(i));
        writable = 1'b1;
        tick();
        rst = 1'b1;
        fetch_req = 1'b1;
        fetch_addr = 12'h7AA;
        tick();
        fetch_req = 1'b0;
        #1;
        vectors++;
        if (pending !== 3'd0 || vram_we !== 1'b0 || fetch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got pending %0d we %b fv %b expected 0 0 0",
                     pending, vram_we, fetch_valid);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (vblank_irq !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_no_irq: got %b expected 0", vblank_irq);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset(1'b1);
        test_drain_order();
        test_fetch_priority();
        test_overflow();
        test_reset(1'b1);
        test_back_to_back();
        test_partial_drain();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
